// File: rtl/consmax_lut_loader_if.sv
// consmax_lut_loader_if: SPI byte stream into the loader and FP LUT write port out of it.
interface consmax_lut_loader_if #(
    parameter int EXP_BIT = 8,
    parameter int MAT_BIT = 7,
    parameter int IDATA_BIT = 8
);
    localparam int LUT_ADDR = IDATA_BIT >> 1;
    localparam int LUT_DATA = EXP_BIT + MAT_BIT + 1;
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [LUT_ADDR:0] lut_waddr;
    logic lut_wen;
    logic [LUT_DATA-1:0] lut_wdata;
    modport master (output in_data, in_valid, input in_ready, lut_waddr, lut_wen, lut_wdata);
    modport slave (input in_data, in_valid, output in_ready, lut_waddr, lut_wen, lut_wdata);
endinterface

// File: rtl/consmax_lut_loader.sv
// consmax_lut_loader: loads the consmax shift config and both FP LUT halves from a byte stream.
// Define CONSMAX_LUT_CHECKSUM_EN to append an XOR checksum byte that drives the sticky chk_err.
module consmax_lut_loader #(
    parameter int CDATA_BIT = 8,
    parameter int EXP_BIT = 8,
    parameter int MAT_BIT = 7,
    parameter int IDATA_BIT = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic abort,
    consmax_lut_loader_if.slave bus,
    output logic [CDATA_BIT-1:0] cfg_consmax_shift,
    output logic busy,
    output logic done,
    output logic chk_err
);
    localparam int LUT_ADDR = IDATA_BIT >> 1;
    localparam int LUT_DATA = EXP_BIT + MAT_BIT + 1;
    localparam int HI_BIT = LUT_DATA - 8;

    typedef enum logic [2:0] {
        IDLE, SHIFT, LO, HI, WRITE
`ifdef CONSMAX_LUT_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    state_t state;
    logic [LUT_ADDR:0] cnt;
    logic [7:0] lo_q;
    logic xfer;

`ifdef CONSMAX_LUT_CHECKSUM_EN
    assign bus.in_ready = state inside {SHIFT, LO, HI, CHK};
`else
    assign bus.in_ready = state inside {SHIFT, LO, HI};
`endif
    assign busy = state != IDLE;
    assign xfer = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            lo_q <= '0;
            cfg_consmax_shift <= '0;
            bus.lut_waddr <= '0;
            bus.lut_wdata <= '0;
            bus.lut_wen <= 1'b0;
            done <= 1'b0;
        end else begin
            bus.lut_wen <= 1'b0;
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= SHIFT;
                        cnt <= '0;
                    end
                    SHIFT: if (xfer) begin
                        cfg_consmax_shift <= CDATA_BIT'(bus.in_data);
                        state <= LO;
                    end
                    LO: if (xfer) begin
                        lo_q <= bus.in_data;
                        state <= HI;
                    end
                    // write strobe is registered here so it is visible during the WRITE cycle
                    HI: if (xfer) begin
                        bus.lut_wen <= 1'b1;
                        bus.lut_waddr <= cnt;
                        bus.lut_wdata <= {HI_BIT'(bus.in_data), lo_q};
                        state <= WRITE;
                    end
                    WRITE: if (&cnt) begin
`ifdef CONSMAX_LUT_CHECKSUM_EN
                        state <= CHK;
`else
                        state <= IDLE;
                        done <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + (LUT_ADDR+1)'(1);
                        state <= LO;
                    end
`ifdef CONSMAX_LUT_CHECKSUM_EN
                    CHK: if (xfer) begin
                        state <= IDLE;
                        done <= 1'b1;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef CONSMAX_LUT_CHECKSUM_EN
    logic [7:0] xor_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xor_q <= '0;
            chk_err <= 1'b0;
        end else if (!abort) begin
            if (state == IDLE && start) begin
                xor_q <= '0;
                chk_err <= 1'b0;
            end else if (xfer && state != CHK) begin
                xor_q <= xor_q ^ bus.in_data;
            end else if (xfer && bus.in_data != xor_q) begin
                chk_err <= 1'b1;
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_consmax_lut_loader.sv
// tb_consmax_lut_loader: directed loads against a write scoreboard; honours CONSMAX_LUT_CHECKSUM_EN.
module tb_consmax_lut_loader;
`ifdef CONSMAX_LUT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int LAT = CHK_EN ? 98 : 97;

    typedef struct {
        logic [4:0] a;
        logic [15:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [7:0] cfg_consmax_shift;
    logic busy, done, chk_err;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    wr_t exp_q[$];
    wr_t e;

    consmax_lut_loader_if bus();

    consmax_lut_loader dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .abort(abort),
        .bus(bus),
        .cfg_consmax_shift(cfg_consmax_shift),
        .busy(busy),
        .done(done),
        .chk_err(chk_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.lut_wen) begin
            check("wen_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("waddr", 32'(bus.lut_waddr), 32'(e.a));
                check("wdata", 32'(bus.lut_wdata), 32'(e.d));
            end
            check("wen_ready_low", 32'(bus.in_ready), 0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_idle", 32'(busy), 0);
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_data = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start(output int c0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic load(input logic [7:0] shift, input bit rnd, input int nwords, input bit corrupt);
        logic [7:0] lo, hi;
        int c0, d0;
`ifdef CONSMAX_LUT_CHECKSUM_EN
        logic [7:0] x;
        x = shift;
`endif
        d0 = done_cnt;
        pulse_start(c0);
        check("busy_after_start", 32'(busy), 1);
        check("chk_err_cleared", 32'(chk_err), 0);
        send(shift, rnd ? int'($urandom_range(0, 1)) : 0);
        for (int w = 0; w < nwords; w++) begin
            lo = (w == 0) ? 8'h34 : 8'($urandom);
            hi = (w == 0) ? 8'h12 : 8'($urandom);
`ifdef CONSMAX_LUT_CHECKSUM_EN
            x = x ^ lo ^ hi;
`endif
            send(lo, rnd ? int'($urandom_range(0, 1)) : 0);
            exp_q.push_back('{a: 5'(w), d: {hi, lo}});
            send(hi, rnd ? int'($urandom_range(0, 1)) : 0);
            if (w == 0) begin
                check("w0_wen", 32'(bus.lut_wen), 1);
                check("w0_wdata", 32'(bus.lut_wdata), 32'h1234);
                check("w0_ready", 32'(bus.in_ready), 0);
            end
        end
        if (nwords == 32) begin
`ifdef CONSMAX_LUT_CHECKSUM_EN
            send(corrupt ? x ^ 8'h01 : x, rnd ? int'($urandom_range(0, 1)) : 0);
`endif
            repeat (6) @(posedge clk);
            #1;
            check("done_once", done_cnt - d0, 1);
            if (!rnd) check("done_latency", done_cyc - c0, LAT);
            check("cfg_shift", 32'(cfg_consmax_shift), 32'(shift));
            check("chk_err", 32'(chk_err), 32'(CHK_EN && corrupt));
            check("queue_empty", exp_q.size(), 0);
            check("busy_end", 32'(busy), 0);
        end
    endtask

    initial begin
        int c0, d0;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(bus.in_ready), 0);
        check("rst_wen", 32'(bus.lut_wen), 0);
        check("rst_cfg", 32'(cfg_consmax_shift), 0);
        check("rst_done", 32'(done), 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        load(8'h05, 1'b0, 32, 1'b0);
        load(8'hA7, 1'b1, 32, 1'b1);

        // start and abort together while idle: stays idle, chk_err untouched
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_idle", 32'(busy), 0);
        check("start_abort_chk_err", 32'(chk_err), 32'(CHK_EN));

        // abort after word 10 is written
        d0 = done_cnt;
        load(8'h11, 1'b0, 11, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        bus.in_data = 8'hEE;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_ready", 32'(bus.in_ready), 0);
        repeat (4) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_queue", exp_q.size(), 0);
        check("abort_cfg", 32'(cfg_consmax_shift), 32'h11);
        load(8'h22, 1'b0, 32, 1'b0);

        // start while busy is ignored, then async reset in HI
        pulse_start(c0);
        send(8'h3C, 0);
        pulse_start(c0);
        send(8'h55, 0);
        check("busy_start_ignored", 32'(cfg_consmax_shift), 32'h3C);
        check("in_hi_ready", 32'(bus.in_ready), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(bus.in_ready), 0);
        check("arst_cfg", 32'(cfg_consmax_shift), 0);
        check("arst_waddr", 32'(bus.lut_waddr), 0);
        check("arst_wdata", 32'(bus.lut_wdata), 0);
        check("arst_wen", 32'(bus.lut_wen), 0);
        check("arst_done", 32'(done), 0);
        check("arst_chk_err", 32'(chk_err), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("final_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
